// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM encodings and counter sizing for the serial ALU
package alu_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int cnt_w(int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/serial_addsub_if.sv
// serial_addsub_if: operand/result handshake bundle of the bit-serial add/sub engine
interface serial_addsub_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             busy;
  modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid, result, cout, ovf, busy);
  modport slave  (input in_valid, op, a, b, out_ready, output in_ready, out_valid, result, cout, ovf, busy);
endinterface

// File: rtl/fulladder.sv
// fulladder: one-bit full adder cell
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/fullsub.sv
// fullsub: one-bit full subtractor cell (a - b - bin)
module fullsub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (bin & ~(a ^ b));
endmodule

// File: rtl/serial_bit_slice.sv
// serial_bit_slice: one add or subtract bit step selected by op
module serial_bit_slice
  import alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic op,
  output logic s,
  output logic cout
);
  logic s_add, c_add, s_sub, c_sub;
  fulladder u_add (.a(a), .b(b), .cin(cin), .s(s_add), .cout(c_add));
  fullsub   u_sub (.a(a), .b(b), .bin(cin), .d(s_sub), .bout(c_sub));
  assign s    = (op == OP_SUB) ? s_sub : s_add;
  assign cout = (op == OP_SUB) ? c_sub : c_add;
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: LSB-first bit-serial add/subtract engine with valid/ready handshakes
module serial_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_addsub_if.slave io
);
  localparam int CNT_W = cnt_w(WIDTH);
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sa_q, sa_d, sb_q, sb_d, res_q, res_d;
  logic               op_q, op_d, am_q, am_d, bm_q, bm_d, c_q, c_d, ovf_q, ovf_d;
  logic               s, co;
  serial_bit_slice u_slice (.a(sa_q[0]), .b(sb_q[0]), .cin(c_q), .op(op_q), .s(s), .cout(co));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    op_d    = op_q;
    am_d    = am_q;
    bm_d    = bm_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: if (io.in_valid) begin
        sa_d    = io.a;
        sb_d    = io.b;
        op_d    = io.op;
        am_d    = io.a[WIDTH-1];
        bm_d    = io.b[WIDTH-1];
        c_d     = 1'b0;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        res_d = {s, res_q[WIDTH-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        c_d   = co;
        cnt_d = cnt_q + CNT_W'(1);
        // s is the result MSB on the last bit step; signs come from the latched operand MSBs
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
          ovf_d   = ((op_q == OP_SUB) ? (am_q != bm_q) : (am_q == bm_q)) & (s != am_q);
        end
      end
      ST_DONE: state_d = io.out_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      op_q    <= 1'b0;
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      op_q    <= op_d;
      am_q    <= am_d;
      bm_q    <= bm_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end
  assign io.in_ready  = (state_q == ST_IDLE);
  assign io.out_valid = (state_q == ST_DONE);
  assign io.busy      = (state_q != ST_IDLE);
  assign io.result    = res_q;
  assign io.cout      = c_q;
  assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and randomized checks of the bit-serial add/sub engine
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  serial_addsub_if #(.WIDTH(8)) io ();
  serial_addsub #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic op);
    logic [8:0] f;
    logic       ov;
    f  = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    ov = (op ? (a[7] != b[7]) : (a[7] == b[7])) && (f[7] != a[7]);
    return {f[7:0], f[8], ov};
  endfunction
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic op,
                       output logic [9:0] got, output int lat, output logic ov_after);
    int n;
    io.a = a; io.b = b; io.op = op; io.in_valid = 1'b1;
    n = 0;
    while (!io.in_ready && n < 50) begin step; n++; end
    step;
    io.in_valid = 1'b0; io.a = ~a; io.b = 8'($urandom); io.op = ~op;
    lat = 0;
    while (!io.out_valid && lat < 50) begin step; lat++; end
    got = {io.result, io.cout, io.ovf};
    step;
    ov_after = io.out_valid;
  endtask
  task automatic test_reset;
    io.in_valid = 1'b0; io.out_ready = 1'b1; io.a = '0; io.b = '0; io.op = 1'b0;
    rst = 1'b1;
    step; step;
    rst = 1'b0;
    checks++;
    if ({io.in_ready, io.out_valid, io.busy, io.result, io.cout, io.ovf} !== {3'b100, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL reset: rdy/vld/busy/res/c/v got %b %b %b %h %b %b want 1 0 0 00 0 0",
               io.in_ready, io.out_valid, io.busy, io.result, io.cout, io.ovf);
    end
    step;
    checks++;
    if (io.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", io.in_ready); end
  endtask
  task automatic test_vec(input string name, input logic [7:0] a, input logic [7:0] b, input logic op,
                          input logic [9:0] exp);
    logic [9:0] got;
    int         lat;
    logic       ov_after;
    do_op(a, b, op, got, lat, ov_after);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: res/c/v got %h %b %b want %h %b %b", name, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
    end
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL %s_latency: got %0d want 8", name, lat); end
    checks++;
    if (ov_after !== 1'b0) begin errors++; $display("FAIL %s_pulse: out_valid after 1 cycle got %b want 0", name, ov_after); end
  endtask
  task automatic test_add;
    test_vec("add_3c_15", 8'h3C, 8'h15, 1'b0, {8'h51, 1'b0, 1'b0});
  endtask
  task automatic test_sub;
    test_vec("sub_10_20", 8'h10, 8'h20, 1'b1, {8'hF0, 1'b1, 1'b0});
    test_vec("sub_80_01", 8'h80, 8'h01, 1'b1, {8'h7F, 1'b0, 1'b1});
  endtask
  task automatic test_wrap;
    test_vec("add_7f_01", 8'h7F, 8'h01, 1'b0, {8'h80, 1'b0, 1'b1});
    test_vec("add_ff_01", 8'hFF, 8'h01, 1'b0, {8'h00, 1'b1, 1'b0});
    test_vec("sub_00_01", 8'h00, 8'h01, 1'b1, {8'hFF, 1'b1, 1'b0});
  endtask
  task automatic test_backpressure;
    int n;
    io.out_ready = 1'b0;
    io.a = 8'h22; io.b = 8'h11; io.op = 1'b1; io.in_valid = 1'b1;
    step;
    io.in_valid = 1'b0; io.a = 8'hEE; io.b = 8'h77;
    n = 0;
    while (!io.out_valid && n < 50) begin step; n++; end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL bp_latency: got %0d want 8", n); end
    io.in_valid = 1'b1; io.a = 8'h05; io.b = 8'h03; io.op = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({io.out_valid, io.in_ready, io.result, io.cout, io.ovf} !== {2'b10, 8'h11, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold%0d: vld/rdy/res/c/v got %b %b %h %b %b want 1 0 11 0 0",
                 i, io.out_valid, io.in_ready, io.result, io.cout, io.ovf);
      end
      step;
    end
    io.out_ready = 1'b1;
    step;
    checks++;
    if ({io.in_ready, io.out_valid, io.busy} !== 3'b100) begin
      errors++;
      $display("FAIL bp_idle: rdy/vld/busy got %b%b%b want 100", io.in_ready, io.out_valid, io.busy);
    end
    step;
    io.in_valid = 1'b0; io.a = 8'hFF; io.b = 8'hFF;
    checks++;
    if ({io.in_ready, io.busy} !== 2'b01) begin
      errors++;
      $display("FAIL bp_accept: rdy/busy got %b%b want 01", io.in_ready, io.busy);
    end
    n = 0;
    while (!io.out_valid && n < 50) begin step; n++; end
    checks++;
    if ({io.result, io.cout, io.ovf} !== {8'h08, 2'b00} || n !== 8) begin
      errors++;
      $display("FAIL bp_next: res/c/v/lat got %h %b %b %0d want 08 0 0 8", io.result, io.cout, io.ovf, n);
    end
    step;
  endtask
  task automatic test_reset_mid_run;
    logic [9:0] got;
    int         lat, seen;
    logic       ov_after;
    io.a = 8'hAA; io.b = 8'h55; io.op = 1'b0; io.in_valid = 1'b1;
    step;
    io.in_valid = 1'b0;
    step; step; step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++;
    if ({io.in_ready, io.out_valid, io.busy, io.result} !== {3'b100, 8'h00}) begin
      errors++;
      $display("FAIL rst_mid: rdy/vld/busy/res got %b %b %b %h want 1 0 0 00", io.in_ready, io.out_valid, io.busy, io.result);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin step; if (io.out_valid) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_no_pulse: out_valid cycles got %0d want 0", seen); end
    do_op(8'h01, 8'h02, 1'b0, got, lat, ov_after);
    checks++;
    if (got !== {8'h03, 2'b00} || lat !== 8) begin
      errors++;
      $display("FAIL rst_after_add: res/c/v/lat got %h %b %b %0d want 03 0 0 8", got[9:2], got[1], got[0], lat);
    end
  endtask
  task automatic test_random;
    logic [7:0] ga, gb;
    logic       gop;
    logic [9:0] exp, held;
    int         n;
    for (int i = 0; i < 1000; i++) begin
      ga = 8'($urandom); gb = 8'($urandom); gop = 1'($urandom);
      exp = model(ga, gb, gop);
      io.out_ready = 1'b1;
      repeat ($urandom_range(0, 3)) step;
      io.a = ga; io.b = gb; io.op = gop; io.in_valid = 1'b1;
      n = 0;
      while (!io.in_ready && n < 50) begin step; n++; end
      step;
      io.in_valid = 1'b0; io.a = 8'($urandom); io.b = 8'($urandom); io.op = 1'($urandom);
      n = 0;
      while (!io.out_valid && n < 50) begin io.out_ready = 1'($urandom); step; n++; end
      checks++;
      if ({io.out_valid, io.result, io.cout, io.ovf} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL rand%0d: %h %s %h vld/res/c/v got %b %h %b %b want 1 %h %b %b", i, ga, gop ? "-" : "+", gb,
                 io.out_valid, io.result, io.cout, io.ovf, exp[9:2], exp[1], exp[0]);
      end
      held = {io.result, io.cout, io.ovf};
      io.out_ready = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        step;
        checks++;
        if ({io.out_valid, io.result, io.cout, io.ovf} !== {1'b1, held}) begin
          errors++;
          $display("FAIL rand_hold%0d: vld/res got %b %h want 1 %h", i, io.out_valid, io.result, held[9:2]);
        end
      end
      io.out_ready = 1'b1;
      step;
      checks++;
      if (io.out_valid !== 1'b0) begin errors++; $display("FAIL rand_dup%0d: out_valid got %b want 0", i, io.out_valid); end
    end
  endtask
  initial begin
    test_reset;
    test_add;
    test_sub;
    test_wrap;
    test_backpressure;
    test_reset_mid_run;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
